// File: rtl/alu_pkg.sv
// Shared ALU encodings: opcode values and status-flag bit positions.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_ADD = 2'b11
    } op_e;

    localparam int FLAGS_W = 4;
    localparam int FLG_P   = 0;
    localparam int FLG_Z   = 1;
    localparam int FLG_N   = 2;
    localparam int FLG_C   = 3;

endpackage

// File: rtl/skid_buf.sv
// Generic 2-entry valid/ready buffer. The main entry drives the output and the
// skid entry catches one beat that was accepted while the output was stalled.
// in_ready comes straight from a flop so upstream sees no combinational path
// from out_ready.
module skid_buf #(
    parameter int DATA_W = 36
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              r_main_valid;
    logic              r_skid_valid;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_main_data;
    logic [DATA_W-1:0] r_skid_data;

    logic w_in_acc;
    logic w_out_xfer;
    logic w_load_main;
    logic w_load_skid;
    logic w_skid_to_main;
    logic w_main_valid_nxt;
    logic w_skid_valid_nxt;

    assign w_in_acc   = in_valid & r_in_ready;
    assign w_out_xfer = r_main_valid & out_ready;

    // Decide where an accepted beat lands and how occupancy changes.
    always_comb begin
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_skid_to_main   = 1'b0;
        w_main_valid_nxt = r_main_valid;
        w_skid_valid_nxt = r_skid_valid;
        if (r_skid_valid) begin
            // Skid full means in_ready is low, so no accept can collide here.
            if (w_out_xfer) begin
                w_skid_to_main   = 1'b1;
                w_skid_valid_nxt = 1'b0;
            end
        end else if (w_in_acc) begin
            if (!r_main_valid || out_ready) begin
                w_load_main      = 1'b1;
                w_main_valid_nxt = 1'b1;
            end else begin
                w_load_skid      = 1'b1;
                w_skid_valid_nxt = 1'b1;
            end
        end else if (w_out_xfer) begin
            w_main_valid_nxt = 1'b0;
        end
    end

    // Occupancy flags and the registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
        end
    end

    // Payload storage; main is cleared on reset so the output reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_data <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_skid_to_main) begin
                r_main_data <= r_skid_data;
            end else if (w_load_main) begin
                r_main_data <= in_data;
            end
            if (w_load_skid) begin
                r_skid_data <= in_data;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: picks one unit result by opcode, derives
// {C,N,Z,P} flags, and hands result+flags to writeback through a skid buffer.
// Also counts completed output transfers with a saturating counter.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   and_res,
    input  logic [WIDTH-1:0]   or_res,
    input  logic [WIDTH-1:0]   xor_res,
    input  logic [WIDTH-1:0]   add_res,
    input  logic               add_cout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   res,
    output logic [FLAGS_W-1:0] flags,
    output logic [CNT_W-1:0]   xfer_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [FLAGS_W-1:0] calc_flags(
        input logic [WIDTH-1:0] r,
        input logic             c
    );
        logic [FLAGS_W-1:0] f;
        f        = '0;
        f[FLG_P] = ^r;
        f[FLG_Z] = (r == '0);
        f[FLG_N] = r[WIDTH-1];
        f[FLG_C] = c;
        return f;
    endfunction

    op_e                      w_op;
    logic [WIDTH-1:0]         w_res_d;
    logic                     w_cout_d;
    logic [WIDTH+FLAGS_W-1:0] w_beat_in;
    logic [WIDTH+FLAGS_W-1:0] w_beat_out;
    logic                     w_out_valid;
    logic [CNT_W-1:0]         r_xfer_cnt;

    assign w_op = op_e'(op);

    // Result mux; carry is only meaningful for the adder.
    always_comb begin
        w_res_d  = and_res;
        w_cout_d = 1'b0;
        case (w_op)
            OP_AND: w_res_d = and_res;
            OP_OR:  w_res_d = or_res;
            OP_XOR: w_res_d = xor_res;
            OP_ADD: begin
                w_res_d  = add_res;
                w_cout_d = add_cout;
            end
            default: w_res_d = and_res;
        endcase
    end

    assign w_beat_in = {calc_flags(w_res_d, w_cout_d), w_res_d};

    skid_buf #(
        .DATA_W(WIDTH + FLAGS_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (w_beat_in),
        .out_valid(w_out_valid),
        .out_ready(out_ready),
        .out_data (w_beat_out)
    );

    // Count output handshakes, sticking at the maximum value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= '0;
        end else if (w_out_valid && out_ready && (r_xfer_cnt != CNT_MAX)) begin
            r_xfer_cnt <= r_xfer_cnt + CNT_ONE;
        end
    end

    assign out_valid = w_out_valid;
    assign res       = w_beat_out[WIDTH-1:0];
    assign flags     = w_beat_out[WIDTH+FLAGS_W-1:WIDTH];
    assign xfer_cnt  = r_xfer_cnt;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: a queue-based reference of the stage contents
// checked every cycle, plus directed scenarios with literal expectations.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [1:0]  op;
    logic [31:0] and_res, or_res, xor_res, add_res;
    logic        add_cout;

    logic        in_ready, out_valid;
    logic [31:0] res;
    logic [3:0]  flags;
    logic [15:0] xfer_cnt;

    logic        in_ready4, out_valid4;
    logic [31:0] res4;
    logic [3:0]  flags4;
    logic [3:0]  xfer_cnt4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .and_res(and_res), .or_res(or_res), .xor_res(xor_res),
        .add_res(add_res), .add_cout(add_cout), .out_valid(out_valid),
        .out_ready(out_ready), .res(res), .flags(flags), .xfer_cnt(xfer_cnt)
    );

    alu_result_stage #(.WIDTH(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .op(op), .and_res(and_res), .or_res(or_res), .xor_res(xor_res),
        .add_res(add_res), .add_cout(add_cout), .out_valid(out_valid4),
        .out_ready(out_ready), .res(res4), .flags(flags4), .xfer_cnt(xfer_cnt4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected {flags,res} of a beat from the arithmetic definition of each flag.
    function automatic logic [35:0] exp_beat(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] x,
                                             input logic [31:0] s, input logic c);
        logic [31:0] r;
        logic        fc, fn, fz, fp;
        case (o)
            2'd0:    r = a;
            2'd1:    r = b;
            2'd2:    r = x;
            default: r = s;
        endcase
        fc = (o == 2'd3) ? c : 1'b0;
        fn = (r >= 32'h8000_0000);
        fz = (r == 32'd0);
        fp = ($countones(r) % 2) == 1;
        return {fc, fn, fz, fp, r};
    endfunction

    // Reference: the stage is a FIFO holding at most two beats.
    logic [35:0] q[$];
    int          n_xfer;

    always @(posedge clk or negedge rst_n) begin
        bit acc, xf;
        if (!rst_n) begin
            q.delete();
            n_xfer = 0;
        end else begin
            acc = in_valid && (q.size() < 2);
            xf  = (q.size() > 0) && out_ready;
            if (xf) begin
                void'(q.pop_front());
                n_xfer++;
            end
            if (acc) q.push_back(exp_beat(op, and_res, or_res, xor_res, add_res, add_cout));
        end
    end

    always @(negedge clk) begin
        check("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
        check("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
        check("xfer_cnt", 64'(xfer_cnt), 64'((n_xfer > 65535) ? 65535 : n_xfer));
        check("xfer_cnt4", 64'(xfer_cnt4), 64'((n_xfer > 15) ? 15 : n_xfer));
        if (q.size() > 0) check("res_flags", 64'({flags, res}), 64'(q[0]));
    end

    // Log of delivered results for order/loss checks.
    logic [31:0] log_q[$];
    int          mon_n;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            log_q.push_back(res);
            mon_n++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] o, input logic [31:0] v);
        in_valid = 1'b1;
        op       = o;
        and_res  = v ^ 32'h1111_1111;
        or_res   = v ^ 32'h2222_2222;
        xor_res  = v ^ 32'h4444_4444;
        add_res  = v;
        add_cout = v[0];
    endtask

    initial begin
        logic [31:0] got;
        mon_n     = 0;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        beat(2'd0, 32'h0);
        and_res   = 32'h0000_1234;

        // Reset with in_valid held high
        step(); step(); step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_xfer_cnt", 64'(xfer_cnt), 64'd0);
        check("rst_res", 64'(res), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        rst_n = 1'b1;
        step();
        check("first_out_valid", 64'(out_valid), 64'd1);
        check("first_res", 64'(res), 64'h1234);

        // Op select literals
        beat(2'd2, 32'h0);
        xor_res = 32'hFFFF_0000;
        step();
        check("xor_res", 64'(res), 64'hFFFF_0000);
        check("xor_flags", 64'(flags), 64'b0100);
        beat(2'd3, 32'h0);
        add_res  = 32'h0;
        add_cout = 1'b1;
        step();
        check("add_res", 64'(res), 64'h0);
        check("add_flags", 64'(flags), 64'b1010);
        in_valid = 1'b0;
        step();
        log_q.delete();

        // Backpressure: beats 1,2 held in main+skid, 3 and 4 stall
        beat(2'd3, 32'd1);
        step();
        beat(2'd3, 32'd2);
        out_ready = 1'b0;
        step();
        beat(2'd3, 32'd3);
        step(); step();
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_res_hold", 64'(res), 64'd1);
        out_ready = 1'b1;
        step(); step();
        beat(2'd3, 32'd4);
        step();
        in_valid = 1'b0;
        step(); step();
        check("bp_count", 64'(log_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            got = (i < log_q.size()) ? log_q[i] : 32'hDEAD_BEEF;
            check("bp_order", 64'(got), 64'(i + 1));
        end

        // Full throughput, also saturates the 4-bit counter
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        mon_n = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            beat(2'($urandom), $urandom);
            step();
        end
        in_valid = 1'b0;
        step();
        check("tp_xfers", 64'(mon_n), 64'd100);
        check("tp_xfer_cnt", 64'(xfer_cnt), 64'd100);
        check("sat_xfer_cnt4", 64'(xfer_cnt4), 64'd15);
        step(); step();
        check("sat_hold", 64'(xfer_cnt4), 64'd15);

        // Async reset while the skid entry is occupied
        out_ready = 1'b0;
        beat(2'd3, 32'hA);
        step();
        beat(2'd3, 32'hB);
        step();
        in_valid = 1'b0;
        check("pre_rst_in_ready", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_res", 64'(res), 64'd0);
        check("arst_xfer_cnt", 64'(xfer_cnt), 64'd0);
        step(); step();
        rst_n = 1'b1;
        log_q.delete();
        out_ready = 1'b1;
        step(); step(); step(); step();
        check("arst_no_pending", 64'(log_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
